// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for serial_subtractor.
// master drives START/A/B and the DUT (slave) returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BO;
    logic             OV;

    modport master (
        output START, A, B,
        input  BUSY, DONE, D, BO, OV
    );

    modport slave (
        input  START, A, B,
        output BUSY, DONE, D, BO, OV
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per RUN cycle.
// The result D/BO/OV is registered on FIN entry and held until the next FIN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bo_q, bo_d;
    logic             ov_q, ov_d;

    logic             start_acc;
    logic             last_bit;
    logic             dbit;
    logic             br_next;
    logic [WIDTH-1:0] diff_shift;

    assign start_acc  = (state_q != RUN) && bus.START;
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    assign dbit       = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign diff_shift = {dbit, diff_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = RUN;
            RUN:     if (last_bit)  state_d = FIN;
            FIN:     state_d = bus.START ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.BUSY = (state_q == RUN);
        bus.DONE = (state_q == FIN);
        bus.D    = dout_q;
        bus.BO   = bo_q;
        bus.OV   = ov_q;
    end

    // Datapath next-state; operand sign bits are kept aside since the shifters lose them
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        diff_d = diff_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        dout_d = dout_q;
        bo_d   = bo_q;
        ov_d   = ov_q;
        if (start_acc) begin
            a_d    = bus.A;
            b_d    = bus.B;
            amsb_d = bus.A[WIDTH-1];
            bmsb_d = bus.B[WIDTH-1];
            diff_d = '0;
            br_d   = 1'b0;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            a_d    = {1'b0, a_q[WIDTH-1:1]};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            diff_d = diff_shift;
            br_d   = br_next;
            cnt_d  = cnt_q + 1'b1;
            if (last_bit) begin
                dout_d = diff_shift;
                bo_d   = br_next;
                ov_d   = (amsb_q != bmsb_q) && (dbit != amsb_q);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            dout_q <= '0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            diff_q <= diff_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            dout_q <= dout_d;
            bo_q   <= bo_d;
            ov_q   <= ov_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results queued at
// operand acceptance and checked cycle by cycle against BUSY/DONE/D/BO/OV.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        bo;
        logic        ov;
        int unsigned due;
        int unsigned start;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    logic        rst_seen = 1'b1;
    bit          mon_en = 1'b0;
    logic [7:0]  last_d = '0;
    logic        last_bo = 1'b0;
    logic        last_ov = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    // Cycle-by-cycle monitor against the queued expectations
    always @(negedge clk) begin
        logic eb;
        logic ed;
        if (mon_en) begin
            if (rst_seen) begin
                sb.delete();
                last_d  = '0;
                last_bo = 1'b0;
                last_ov = 1'b0;
            end
            eb = (sb.size() > 0) && (cyc > sb[0].start) && (cyc < sb[0].due);
            ed = (sb.size() > 0) && (cyc == sb[0].due);
            chk("busy", bus.BUSY, eb);
            chk("done", bus.DONE, ed);
            if (ed) begin
                last_d  = sb[0].d;
                last_bo = sb[0].bo;
                last_ov = sb[0].ov;
                void'(sb.pop_front());
            end
            chk("d",  bus.D,  last_d);
            chk("bo", bus.BO, last_bo);
            chk("ov", bus.OV, last_ov);
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                         input logic bo, input logic ov, input bit hold);
        int unsigned n = 0;
        @(negedge clk);
        while (bus.BUSY && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.BUSY) chk("issue_wait", bus.BUSY, 1'b0);
        bus.A     = a;
        bus.B     = b;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{d: d, bo: bo, ov: ov, due: cyc + 8, start: cyc - 1});
        if (!hold) bus.START = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] a, b, d;
        logic       bo, ov;

        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_done", bus.DONE, 1'b0);
        chk("rst_d",    bus.D,    8'h00);
        chk("rst_bo",   bus.BO,   1'b0);
        chk("rst_ov",   bus.OV,   1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Directed vectors
        issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        drain();
        issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        drain();
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        drain();
        issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        drain();

        // START pulses during RUN with other operands must be ignored
        issue(8'h5A, 8'h33, 8'h27, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.A = 8'hFF; bus.B = 8'h11; bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        @(negedge clk);
        bus.A = 8'h01; bus.B = 8'h80; bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        drain();

        // Reset in RUN cycle 4 aborts; START accepted on the first edge after release
        issue(8'h44, 8'h22, 8'h22, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.BUSY, 1'b0);
        chk("abort_done", bus.DONE, 1'b0);
        chk("abort_d",    bus.D,    8'h00);
        chk("abort_bo",   bus.BO,   1'b0);
        chk("abort_ov",   bus.OV,   1'b0);
        rst_n     = 1'b1;
        bus.A     = 8'h10;
        bus.B     = 8'h01;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{d: 8'h0F, bo: 1'b0, ov: 1'b0, due: cyc + 8, start: cyc - 1});
        bus.START = 1'b0;
        drain();

        // Back-to-back random operands with START held high
        for (int i = 0; i < 1000; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            d  = a - b;
            bo = (a < b);
            ov = (a[7] != b[7]) && (d[7] != a[7]);
            issue(a, b, d, bo, ov, 1'b1);
        end
        bus.START = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port START  input  1  request to begin A-B; sampled only when BUSY=0.
REQ-005 SHALL have port A  input  WIDTH  minuend, captured on accepted START.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, captured on accepted START.
REQ-007 SHALL have port BUSY  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port DONE  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port D  output  WIDTH  difference A-B modulo 2^WIDTH.
REQ-010 SHALL have port BO  output  1  borrow out: 1 iff unsigned A < B.
REQ-011 SHALL have port OV  output  1  signed two's-complement overflow of A-B.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIN; reset state IDLE.
REQ-013 SHALL, in IDLE or FIN with START=1, capture A and B into shift registers, clear borrow and bit counter, and enter RUN next cycle.
REQ-014 SHALL ignore START while in RUN (BUSY=1); captured operands unaffected.
REQ-015 SHALL process one bit per RUN cycle, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 SHALL shift operand registers right by one each RUN cycle and shift d into the MSB of the difference register.
REQ-017 SHALL count bits 0..WIDTH-1; after the bit-WIDTH-1 cycle, enter FIN.
REQ-018 SHALL assert BUSY combinationally from state: 1 in RUN only.
REQ-019 SHALL assert DONE for exactly one cycle, in FIN; START at cycle 0 gives DONE at cycle WIDTH+1.
REQ-020 SHALL update D, BO, OV registered on entry to FIN and hold them stable until the next FIN entry or reset.
REQ-021 SHALL compute OV = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]) using captured A, B.
REQ-022 SHALL accept START in FIN (back-to-back): DONE still pulses that cycle, RUN begins next cycle, D/BO/OV retain previous result until new FIN.
REQ-023 SHALL return from FIN to IDLE when START=0.
REQ-024 SHALL treat A or B changing after capture as don't-care.

Reset
REQ-025 SHALL, while RST_N=0 at a rising edge, force state IDLE, BUSY=0, DONE=0, D=0, BO=0, OV=0, internal registers 0.
REQ-026 SHALL abort any in-progress subtraction on reset, with no DONE pulse for it.
REQ-027 SHALL accept START on the first edge after RST_N returns to 1.

Verification (WIDTH=8)
REQ-028 SHALL cover: A=0x05, B=0x03, START cycle 0 -> BUSY cycles 1-8, DONE cycle 9, D=0x02, BO=0, OV=0.
REQ-029 SHALL cover: A=0x03, B=0x05 -> D=0xFE, BO=1, OV=0.
REQ-030 SHALL cover: A=0x80, B=0x01 -> D=0x7F, BO=0, OV=1; and A=0x7F, B=0xFF -> D=0x80, BO=1, OV=1.
REQ-031 SHALL cover: START pulsed in cycles 3 and 5 of a run with different A/B -> ignored, result of original operands, single DONE.
REQ-032 SHALL cover: RST_N=0 at RUN cycle 4 -> next cycle all outputs 0, no DONE; new START 0x10-0x01 after release -> D=0x0F at DONE.
REQ-033 SHALL cover: START held high through FIN -> DONE pulses every 9 cycles, BUSY low only in FIN cycles, each result correct against reference model over 1000 random pairs.
